l2_round_robin_arbiter: RTL and testbench

Registered round-robin arbiter that drives the slave side of the L2 arbitration interface. It accepts per-port request bits and a strobe, and produces a stable one-hot grant plus the matching binary grant index. It sits in the L2 arbiter between the per-port request queues and the shared L2 request path. A grant-hold watchdog flags a granted port that the datapath never accepts.

---
 rtl/l2_round_robin_arbiter_if.sv | 20 ++
 rtl/l2_round_robin_arbiter.sv | 71 +++++++
 tb/tb_l2_round_robin_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/l2_round_robin_arbiter_if.sv
// l2_round_robin_arbiter_if: request/strobe in, registered grant out for the L2 arbiter
interface l2_round_robin_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  localparam int IW = $clog2(NUM_PORTS);
  logic [NUM_PORTS-1:0] requests;
  logic                 strobe;
  logic [IW-1:0]        grantee_i;
  logic [NUM_PORTS-1:0] grantee_v;
  logic                 grantee_valid;
  logic                 timeout_error;
  modport master (
    output requests, strobe,
    input  grantee_i, grantee_v, grantee_valid, timeout_error
  );
  modport slave (
    input  requests, strobe,
    output grantee_i, grantee_v, grantee_valid, timeout_error
  );
endinterface

// File: rtl/l2_round_robin_arbiter.sv
// l2_round_robin_arbiter: registered round-robin grant with no-bubble handoff and a grant-hold watchdog
module l2_round_robin_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                   clk,
  input logic                   rst_n,
  l2_round_robin_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_PORTS);
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t               state, state_nxt;
  logic [IW-1:0]        ptr, ptr_nxt, gi, win;
  logic [NUM_PORTS-1:0] gv;
  logic                 srv, found, ld;
  logic [IW:0]          idx;
  always_comb begin
    srv     = (state == GRANTED) && bus.strobe;
    ptr_nxt = srv ? ((gi == IW'(NUM_PORTS - 1)) ? '0 : gi + IW'(1)) : ptr;
    found   = 1'b0;
    win     = '0;
    idx     = '0;
    // scan from lowest priority up so the highest-priority hit is written last
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_nxt} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_PORTS)) idx = idx - (IW+1)'(NUM_PORTS);
      if (bus.requests[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
    ld        = ((state == IDLE) || srv) && found;
    state_nxt = ld ? GRANTED : (srv ? IDLE : state);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      gi    <= '0;
      gv    <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (ld) gi <= win;
      gv <= ld ? NUM_PORTS'(1) << win : (srv ? '0 : gv);
    end
  end
  assign bus.grantee_i     = gi;
  assign bus.grantee_v     = gv;
  assign bus.grantee_valid = (state == GRANTED);
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] cnt;
      logic          err, hold;
      assign hold = (state == GRANTED) && !bus.strobe;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt <= '0;
          err <= 1'b0;
        end else begin
          cnt <= !hold ? '0 : (cnt != CW'(TIMEOUT_CYCLES) ? cnt + CW'(1) : cnt);
          if (hold && cnt == CW'(TIMEOUT_CYCLES - 1)) err <= 1'b1;
        end
      end
      assign bus.timeout_error = err;
    end else begin : g_nowd
      assign bus.timeout_error = 1'b0;
    end
  endgenerate
endmodule

// File: tb/tb_l2_round_robin_arbiter.sv
// tb_l2_round_robin_arbiter: directed stimulus with a queued scoreboard checked by a negedge monitor
module tb_l2_round_robin_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  typedef struct {
    logic       v;
    logic [1:0] i;
    logic [3:0] oh;
    logic       e;
    string      name;
  } exp_t;
  exp_t sb[$];
  l2_round_robin_arbiter_if #(.NUM_PORTS(4)) bus ();
  l2_round_robin_arbiter #(.NUM_PORTS(4), .TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic step(input logic [3:0] req, input logic stb, input logic rn,
                      input logic v, input logic [1:0] i, input logic [3:0] oh,
                      input logic e, input string name);
    exp_t x;
    bus.requests = req;
    bus.strobe   = stb;
    rst_n        = rn;
    @(posedge clk);
    #1;
    x.v = v; x.i = i; x.oh = oh; x.e = e; x.name = name;
    sb.push_back(x);
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      if (bus.grantee_valid !== x.v || bus.grantee_i !== x.i ||
          bus.grantee_v !== x.oh || bus.timeout_error !== x.e) begin
        errors++;
        $display("FAIL %s: got v=%b i=%0d oh=%b err=%b, expected v=%b i=%0d oh=%b err=%b",
                 x.name, bus.grantee_valid, bus.grantee_i, bus.grantee_v, bus.timeout_error,
                 x.v, x.i, x.oh, x.e);
      end
    end
  end
  initial begin
    bus.requests = '0;
    bus.strobe   = 1'b0;
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, "reset0");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, "reset1");
    step(4'b1010, 0, 1, 1, 1, 4'b0010, 0, "first_grant");
    for (int k = 0; k < 5; k++)
      step(4'b0000, 0, 1, 1, 1, 4'b0010, k >= 3, "hold");
    step(4'b0000, 1, 1, 0, 1, 4'b0000, 1, "serve_empty");
    step(4'b1001, 0, 1, 1, 3, 4'b1000, 1, "ptr2_wins3");
    step(4'b1001, 1, 1, 1, 0, 4'b0001, 1, "wrap_to0");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, "reset_clears_err");
    step(4'b1111, 0, 1, 1, 0, 4'b0001, 0, "b2b_start");
    step(4'b1111, 1, 1, 1, 1, 4'b0010, 0, "b2b_1");
    step(4'b1111, 1, 1, 1, 2, 4'b0100, 0, "b2b_2");
    step(4'b1111, 1, 1, 1, 3, 4'b1000, 0, "b2b_3");
    step(4'b1111, 1, 1, 1, 0, 4'b0001, 0, "b2b_0");
    step(4'b1111, 1, 1, 1, 1, 4'b0010, 0, "b2b_1b");
    for (int k = 0; k < 4; k++)
      step(4'b1111, 0, 1, 1, 1, 4'b0010, k == 3, "watchdog");
    step(4'b1111, 1, 1, 1, 2, 4'b0100, 1, "err_sticky_strobe");
    step(4'b1111, 0, 1, 1, 2, 4'b0100, 1, "err_sticky_hold");
    step(4'b1111, 0, 0, 0, 0, 4'b0000, 0, "reset_mid_grant");
    step(4'b1111, 0, 1, 1, 0, 4'b0001, 0, "after_reset_grant0");
    step(4'b0000, 1, 1, 0, 0, 4'b0000, 0, "serve0_empty");
    step(4'b0000, 1, 1, 0, 0, 4'b0000, 0, "idle_strobe_ignored");
    step(4'b0100, 1, 1, 1, 2, 4'b0100, 0, "idle_grant2");
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
